// File: rtl/mux_tree_cfgchain.sv
// Routing mux tree with a private serial configuration chain.
// Select bits are shifted in, odd-parity checked, then committed atomically.
module mux_tree_cfgchain #(
    parameter int unsigned NUM_IN = 10,
    parameter int unsigned SEL_W  = $clog2(NUM_IN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              cfg_en,
    input  logic              ccff_head,
    input  logic [NUM_IN-1:0] in,
    output logic              out,
    output logic              ccff_tail,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int unsigned WORD_W  = SEL_W + 1;
    localparam int unsigned CNT_MAX = WORD_W + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned SPAN    = 2 ** SEL_W;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic [WORD_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;
    logic [SEL_W-1:0]  sel_q;
    logic [SPAN-1:0]   in_ext;
    logic              word_ok;

    // Unused select codes index into the all-ones padding, routing const1.
    always_comb begin
        in_ext  = {{(SPAN - NUM_IN){1'b1}}, in};
        out     = in_ext[sel_q];
        word_ok = (cnt == CNT_W'(WORD_W)) && (^sr);
    end

    assign ccff_tail = sr[WORD_W-1];

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            sel_q    <= '1;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_en) begin
                        sr    <= {sr[WORD_W-2:0], ccff_head};
                        cnt   <= CNT_W'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cfg_en) begin
                        sr <= {sr[WORD_W-2:0], ccff_head};
                        // Saturate one past a full word so overrun stays visible.
                        if (cnt != CNT_W'(CNT_MAX))
                            cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt      <= '0;
                        state    <= IDLE;
                        cfg_done <= 1'b1;
                        if (word_ok) begin
                            sel_q   <= sr[WORD_W-1:1];
                            cfg_err <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
